// File: rtl/sdf_stage_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | sdf_stage_ctrl_pkg : shared constants and state type for SDF stages  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package sdf_stage_ctrl_pkg;

  localparam int DATA_IN_WIDTH = 16;
  localparam int FFT_N_DEFAULT = 256;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_FILL_ENC  = 2'd1;
  localparam logic [1:0] ST_RUN_ENC   = 2'd2;
  localparam logic [1:0] ST_FLUSH_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_FILL  = ST_FILL_ENC,
    ST_RUN   = ST_RUN_ENC,
    ST_FLUSH = ST_FLUSH_ENC
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sdf_stage_ctrl.sv
// +----------------------------------------------------------------------+
// | sdf_stage_ctrl : sequencing controller for one R2SDF (DIF) FFT stage |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sdf_stage_ctrl
  import sdf_stage_ctrl_pkg::*;
#(
  parameter  int FFT_N     = FFT_N_DEFAULT,
  parameter  int FFT_STAGE = 1,
  localparam int CNT_W     = $clog2(FFT_N),
  localparam int TW_AW     = $clog2(FFT_N) - 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             di_valid,
  output logic             dly_en,
  output logic             bf_sel,
  output logic             tw_en,
  output logic [TW_AW-1:0] tw_addr,
  output logic             do_valid,
  output logic             frame_done,
  output logic             busy,
  output logic             err_resync
);

  localparam int D      = FFT_N >> FFT_STAGE;
  localparam int LD     = $clog2(D);
  localparam int HALF_W = (LD > 0) ? LD : 1;

  localparam logic [CNT_W-1:0]  LAST_IN   = CNT_W'(FFT_N - 1);
  localparam logic [CNT_W-1:0]  FILL_LEN  = CNT_W'(D);
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(D - 1);
  localparam logic [HALF_W-1:0] HALF_ONE  = (D > 1) ? HALF_W'(1) : '0;
  // A one-deep delay has nothing to fill, so the first sample goes straight to RUN.
  localparam state_t FIRST_ST = (D == 1) ? ST_RUN : ST_FILL;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [HALF_W-1:0]  half_cnt_q, half_cnt_d;
  logic [HALF_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic               drain_q, drain_d;
  logic               err_q, err_d;
  logic               do_valid_q, do_valid_d;
  logic               tw_en_q, tw_en_d;
  logic [TW_AW-1:0]   tw_addr_q, tw_addr_d;
  logic               frame_done_q, frame_done_d;

  logic               new_frame;
  logic               out_fire;
  logic               out_diff;
  logic               out_last;
  logic [HALF_W-1:0]  out_idx;
  logic [HALF_W-1:0]  half_inc;
  logic [HALF_W-1:0]  flush_inc;

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    half_cnt_d  = half_cnt_q;
    flush_cnt_d = flush_cnt_q;
    drain_d     = drain_q;
    err_d       = err_q;
    dly_en      = 1'b0;
    bf_sel      = 1'b0;
    out_fire    = 1'b0;
    out_diff    = 1'b0;
    out_last    = 1'b0;
    out_idx     = '0;
    new_frame   = start & di_valid;
    half_inc    = (half_cnt_q == LAST_HALF) ? '0 : half_cnt_q + HALF_W'(1);
    flush_inc   = (flush_cnt_q == LAST_HALF) ? '0 : flush_cnt_q + HALF_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (new_frame) begin
          dly_en     = 1'b1;
          state_d    = FIRST_ST;
          in_cnt_d   = CNT_W'(1);
          half_cnt_d = HALF_ONE;
        end
      end

      ST_FILL, ST_RUN: begin
        dly_en = di_valid;
        if (new_frame) begin
          err_d      = 1'b1;
          drain_d    = 1'b0;
          state_d    = FIRST_ST;
          in_cnt_d   = CNT_W'(1);
          half_cnt_d = HALF_ONE;
        end else if (di_valid) begin
          bf_sel     = in_cnt_q[LD];
          in_cnt_d   = in_cnt_q + CNT_W'(1);
          half_cnt_d = half_inc;
          if (state_q == ST_FILL) begin
            if (half_cnt_q == LAST_HALF) state_d = ST_RUN;
          end else if (drain_q) begin
            // Tail of the previous frame's differences leaving the delay line.
            out_fire    = 1'b1;
            out_diff    = 1'b1;
            out_idx     = flush_cnt_q;
            out_last    = (flush_cnt_q == LAST_HALF);
            flush_cnt_d = flush_inc;
            if (flush_cnt_q == LAST_HALF) drain_d = 1'b0;
          end else if (in_cnt_q >= FILL_LEN) begin
            out_fire = 1'b1;
            out_diff = ~in_cnt_q[LD];
            out_idx  = half_cnt_q;
          end
          if (in_cnt_q == LAST_IN) begin
            state_d     = ST_FLUSH;
            in_cnt_d    = '0;
            half_cnt_d  = '0;
            flush_cnt_d = '0;
          end
        end
      end

      ST_FLUSH: begin
        dly_en      = 1'b1;
        out_fire    = 1'b1;
        out_diff    = 1'b1;
        out_idx     = flush_cnt_q;
        out_last    = (flush_cnt_q == LAST_HALF);
        flush_cnt_d = flush_inc;
        if (new_frame) begin
          state_d    = ST_RUN;
          in_cnt_d   = CNT_W'(1);
          half_cnt_d = HALF_ONE;
          drain_d    = (flush_cnt_q != LAST_HALF);
        end else if (flush_cnt_q == LAST_HALF) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    do_valid_d   = out_fire;
    tw_en_d      = out_fire & out_diff;
    tw_addr_d    = (out_fire & out_diff) ? (TW_AW'(out_idx) << (FFT_STAGE - 1)) : '0;
    frame_done_d = out_fire & out_last;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      in_cnt_q     <= '0;
      half_cnt_q   <= '0;
      flush_cnt_q  <= '0;
      drain_q      <= 1'b0;
      err_q        <= 1'b0;
      do_valid_q   <= 1'b0;
      tw_en_q      <= 1'b0;
      tw_addr_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      half_cnt_q   <= half_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      drain_q      <= drain_d;
      err_q        <= err_d;
      do_valid_q   <= do_valid_d;
      tw_en_q      <= tw_en_d;
      tw_addr_q    <= tw_addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tw_en      = tw_en_q;
  assign tw_addr    = tw_addr_q;
  assign do_valid   = do_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);
  assign err_resync = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sdf_stage_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_sdf_stage_ctrl : directed vector bench, N=16 at stages 1 and 3    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_sdf_stage_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start1 = 1'b0, dv1 = 1'b0, start3 = 1'b0, dv3 = 1'b0;

  logic       d1_dly, d1_bf, d1_twe, d1_vld, d1_fd, d1_busy, d1_err;
  logic [2:0] d1_twa;
  logic       d3_dly, d3_bf, d3_twe, d3_vld, d3_fd, d3_busy, d3_err;
  logic [2:0] d3_twa;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdf_stage_ctrl #(.FFT_N(16), .FFT_STAGE(1)) u_dut_s1 (
    .clk(clk), .rstn(rstn), .start(start1), .di_valid(dv1),
    .dly_en(d1_dly), .bf_sel(d1_bf), .tw_en(d1_twe), .tw_addr(d1_twa),
    .do_valid(d1_vld), .frame_done(d1_fd), .busy(d1_busy), .err_resync(d1_err)
  );

  sdf_stage_ctrl #(.FFT_N(16), .FFT_STAGE(3)) u_dut_s3 (
    .clk(clk), .rstn(rstn), .start(start3), .di_valid(dv3),
    .dly_en(d3_dly), .bf_sel(d3_bf), .tw_en(d3_twe), .tw_addr(d3_twa),
    .do_valid(d3_vld), .frame_done(d3_fd), .busy(d3_busy), .err_resync(d3_err)
  );

  typedef struct {
    bit       sel3;
    bit       start;
    bit       dv;
    bit       dly;
    bit       bf;
    bit       busy;
    bit       vld;
    bit       twe;
    bit [2:0] twa;
    bit       fd;
    bit       err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit sel3, bit st, bit dv, bit dly, bit bf, bit bsy,
                              bit vld, bit twe, bit [2:0] twa, bit fd, bit err);
    vec_t v;
    v.sel3 = sel3; v.start = st; v.dv = dv; v.dly = dly; v.bf = bf; v.busy = bsy;
    v.vld = vld; v.twe = twe; v.twa = twa; v.fd = fd; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    start1 = v.sel3 ? 1'b0 : v.start;
    dv1    = v.sel3 ? 1'b0 : v.dv;
    start3 = v.sel3 ? v.start : 1'b0;
    dv3    = v.sel3 ? v.dv : 1'b0;
    #1;
    n_vec++;
    chk("dly_en", idx, {7'd0, v.sel3 ? d3_dly : d1_dly}, {7'd0, v.dly});
    chk("bf_sel", idx, {7'd0, v.sel3 ? d3_bf : d1_bf}, {7'd0, v.bf});
    chk("busy",   idx, {7'd0, v.sel3 ? d3_busy : d1_busy}, {7'd0, v.busy});
    @(posedge clk);
    #1;
    chk("do_valid",   idx, {7'd0, v.sel3 ? d3_vld : d1_vld}, {7'd0, v.vld});
    chk("tw_en",      idx, {7'd0, v.sel3 ? d3_twe : d1_twe}, {7'd0, v.twe});
    chk("tw_addr",    idx, {5'd0, v.sel3 ? d3_twa : d1_twa}, {5'd0, v.twa});
    chk("frame_done", idx, {7'd0, v.sel3 ? d3_fd : d1_fd}, {7'd0, v.fd});
    chk("err_resync", idx, {7'd0, v.sel3 ? d3_err : d1_err}, {7'd0, v.err});
  endtask

  initial begin
    // T1: D=8 continuous frame, 8 silent inputs, 8 sums, 8 twiddled flush outputs.
    for (int c = 0; c < 25; c++)
      vecs.push_back(mk(1'b0, c == 0, c < 16, c < 24, c >= 8 && c < 16, c >= 1 && c < 24,
                        c >= 8 && c < 24, c >= 16 && c < 24,
                        (c >= 16 && c < 24) ? 3'(c - 16) : 3'd0, c == 23, 1'b0));
    // T2: D=2 continuous, bf_sel 0,0,1,1 and bypass twiddles 0,4.
    for (int c = 0; c < 19; c++) begin
      bit bf, vld, twe;
      bf  = (c < 16) && ((c & 2) != 0);
      vld = (c >= 2) && (c < 18);
      twe = vld && !bf;
      vecs.push_back(mk(1'b1, c == 0, c < 16, c < 18, bf, c >= 1 && c < 18,
                        vld, twe, (twe && (c & 1) != 0) ? 3'd4 : 3'd0, c == 17, 1'b0));
    end
    // T3: D=8 with di_valid alternating 1,0.
    for (int c = 0; c < 40; c++) begin
      bit ev;
      ev = (c % 2) == 0;
      vecs.push_back(mk(1'b0, c == 0, c <= 30 && ev, (c <= 30) ? ev : (c <= 38),
                        ev && c >= 16 && c <= 30, c >= 1 && c <= 38,
                        (ev && c >= 16 && c <= 30) || (c >= 31 && c <= 38),
                        c >= 31 && c <= 38, (c >= 31 && c <= 38) ? 3'(c - 31) : 3'd0,
                        c == 38, 1'b0));
    end
    // T4: back-to-back frames, second start lands on the first flush cycle.
    for (int c = 0; c < 41; c++) begin
      bit twe;
      twe = (c >= 16 && c < 24) || (c >= 32 && c < 40);
      vecs.push_back(mk(1'b0, c == 0 || c == 16, c < 32, c < 40,
                        (c >= 8 && c < 16) || (c >= 24 && c < 32), c >= 1 && c < 40,
                        c >= 8 && c < 40, twe, twe ? 3'(c & 7) : 3'd0,
                        c == 23 || c == 39, 1'b0));
    end
    // T5: restart on the fifth input of a frame.
    for (int c = 0; c < 29; c++)
      vecs.push_back(mk(1'b0, c == 0 || c == 4, c < 20, c < 28, c >= 12 && c < 20,
                        c >= 1 && c < 28, c >= 12 && c < 28, c >= 20 && c < 28,
                        (c >= 20 && c < 28) ? 3'(c - 20) : 3'd0, c == 27, c >= 4));

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    chk("rst_busy",   0, {6'd0, d1_busy, d3_busy}, 8'd0);
    chk("rst_vld",    0, {6'd0, d1_vld, d3_vld}, 8'd0);
    chk("rst_err",    0, {6'd0, d1_err, d3_err}, 8'd0);
    chk("rst_fd_twe", 0, {4'd0, d1_fd, d3_fd, d1_twe, d3_twe}, 8'd0);
    chk("rst_twa",    0, {2'd0, d1_twa, d3_twa}, 8'd0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[i]) apply(vecs[i], i);

    // T6: reset pulse in the middle of RUN.
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      start1 = (c == 0);
      dv1    = 1'b1;
    end
    @(posedge clk);
    #1;
    n_vec++;
    chk("pre_rst_vld", 900, {7'd0, d1_vld}, 8'd1);
    chk("pre_rst_err", 900, {7'd0, d1_err}, 8'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_vec++;
    chk("async_rst_vld",  901, {7'd0, d1_vld}, 8'd0);
    chk("async_rst_busy", 901, {7'd0, d1_busy}, 8'd0);
    chk("async_rst_err",  901, {7'd0, d1_err}, 8'd0);
    chk("async_rst_dly",  901, {7'd0, d1_dly}, 8'd0);
    chk("async_rst_bf",   901, {7'd0, d1_bf}, 8'd0);
    chk("async_rst_tw",   901, {4'd0, d1_twe, d1_twa}, 8'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      dv1    = 1'b1;
      #1;
      n_vec++;
      chk("post_rst_dly",  902 + c, {7'd0, d1_dly}, 8'd0);
      chk("post_rst_busy", 902 + c, {7'd0, d1_busy}, 8'd0);
      @(posedge clk);
      #1;
      chk("post_rst_vld",  902 + c, {7'd0, d1_vld}, 8'd0);
    end
    dv1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
